// File: rtl/pattern_broadcaster.sv
// pattern_broadcaster: drives the adder-under-test operands {cin,b,a}
// from two scan pins. Broadcast replicates the pins, shift serially
// loads full operands, and count sweeps every {cin,b,a} combination.
// busy/done let the tester pace pattern application.
module pattern_broadcaster #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         start,
    input  logic         abort,
    input  logic         pin_a,
    input  logic         pin_b,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic         busy,
    output logic         done
);

    // Width of the shift bit counter; derived from N and not overridable.
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // The count sweep treats {cin,b,a} as one unsigned word.
    localparam int VEC_W = 2 * N + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        MODE_BCAST = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    state_e           state_q;
    mode_e            mode_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    // Only N-1 history bits are stored: the final load takes the live pin
    // bit as the MSB, so a full N-bit register would never use its LSB.
    logic [N-2:0]     sr_a_q;
    logic [N-2:0]     sr_b_q;
    logic [N-1:0]     sr_a_d;
    logic [N-1:0]     sr_b_d;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             cin_q;
    logic             busy_q;
    logic             done_q;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;
    logic             vec_last;
    logic             shift_last;

    assign vec_q = {cin_q, b_q, a_q};

    // Next-value arithmetic shared by the shift and count states.
    // NOTE: every signal driven here has an unconditional assignment, so no latch can be inferred.
    always_comb begin
        mode_s     = mode_e'(mode);
        sr_a_d     = {pin_a, sr_a_q};
        sr_b_d     = {pin_b, sr_b_q};
        cnt_d      = cnt_q + CNT_W'(1);
        vec_d      = vec_q + VEC_W'(1);
        vec_last   = &vec_q;
        shift_last = (cnt_q == CNT_LAST);
    end

    // Control FSM with registered operand, busy and done outputs.
    // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_a_q  <= '0;
            sr_b_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless a completion re-arms it below.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    case (mode_s)
                        MODE_BCAST: begin
                            a_q   <= {N{pin_a}};
                            b_q   <= {N{pin_b}};
                            cin_q <= pin_a ^ pin_b;
                        end
                        MODE_SHIFT: begin
                            // abort in IDLE only suppresses start.
                            if (start && !abort) begin
                                state_q <= ST_SHIFT;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                                cin_q   <= pin_a;
                            end
                        end
                        MODE_COUNT: begin
                            if (start && !abort) begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                                a_q     <= '0;
                                b_q     <= '0;
                                cin_q   <= 1'b0;
                            end
                        end
                        default: begin
                            // HOLD: operands keep their values, start ignored.
                        end
                    endcase
                end

                ST_SHIFT: begin
                    if (abort) begin
                        // Partial data stays in the shifter and is never loaded.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        sr_a_q <= sr_a_d[N-1:1];
                        sr_b_q <= sr_b_d[N-1:1];
                        cnt_q  <= cnt_d;
                        if (shift_last) begin
                            // Operands change in one step, never bit by bit.
                            a_q     <= sr_a_d;
                            b_q     <= sr_b_d;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // All-ones naturally wraps to zero on the increment.
                        {cin_q, b_q, a_q} <= vec_d;
                        if (vec_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // busy drops on the same edge that raises done, so they never overlap.
    assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));

    assign a    = a_q;
    assign b    = b_q;
    assign cin  = cin_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pattern_broadcaster.sv
// tb_pattern_broadcaster: three instances (N=16 broadcast, N=4 shift,
// N=2 count sweep) checked against a transaction-level reference model.
module tb_pattern_broadcaster;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pin_a = 1'b0;
    logic pin_b = 1'b0;

    logic [1:0] mode16 = 2'b11, mode4 = 2'b11, mode2 = 2'b11;
    logic start16 = 1'b0, start4 = 1'b0, start2 = 1'b0;
    logic abort16 = 1'b0, abort4 = 1'b0, abort2 = 1'b0;

    logic [15:0] a16, b16;
    logic        cin16, busy16, done16;
    logic [3:0]  a4, b4;
    logic        cin4, busy4, done4;
    logic [1:0]  a2, b2;
    logic        cin2, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: expected operand values of each instance.
    logic [15:0] m16_a, m16_b;
    logic        m16_cin;
    logic [3:0]  m4_a, m4_b;
    logic        m4_cin;
    logic [4:0]  m2_val;

    pattern_broadcaster #(.N(16)) u16 (
        .clk(clk), .rst(rst), .mode(mode16), .start(start16), .abort(abort16),
        .pin_a(pin_a), .pin_b(pin_b),
        .a(a16), .b(b16), .cin(cin16), .busy(busy16), .done(done16)
    );

    pattern_broadcaster #(.N(4)) u4 (
        .clk(clk), .rst(rst), .mode(mode4), .start(start4), .abort(abort4),
        .pin_a(pin_a), .pin_b(pin_b),
        .a(a4), .b(b4), .cin(cin4), .busy(busy4), .done(done4)
    );

    pattern_broadcaster #(.N(2)) u2 (
        .clk(clk), .rst(rst), .mode(mode2), .start(start2), .abort(abort2),
        .pin_a(pin_a), .pin_b(pin_b),
        .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model;
        m16_a = '0; m16_b = '0; m16_cin = 1'b0;
        m4_a = '0; m4_b = '0; m4_cin = 1'b0;
        m2_val = '0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        zero_model();
        n_cmp++;
        if ({a16, b16, cin16, busy16, done16} !== '0) begin
            n_bad++;
            $display("FAIL reset_n16: got a=%h b=%h cin=%b busy=%b done=%b, want all zero",
                     a16, b16, cin16, busy16, done16);
        end
        n_cmp++;
        if ({a4, b4, cin4, busy4, done4} !== '0) begin
            n_bad++;
            $display("FAIL reset_n4: got a=%h b=%h cin=%b busy=%b done=%b, want all zero",
                     a4, b4, cin4, busy4, done4);
        end
        n_cmp++;
        if ({a2, b2, cin2, busy2, done2} !== '0) begin
            n_bad++;
            $display("FAIL reset_n2: got a=%h b=%h cin=%b busy=%b done=%b, want all zero",
                     a2, b2, cin2, busy2, done2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Broadcast on the N=16 instance: two directed pin pairs then random ones,
    // followed by HOLD cycles where pins and start must be ignored.
    task automatic test_bcast;
        mode16 = 2'b00;
        for (int i = 0; i < 22; i++) begin
            bit pa, pb;
            if (i == 0) begin pa = 1'b0; pb = 1'b1; end
            else if (i == 1) begin pa = 1'b1; pb = 1'b0; end
            else begin pa = 1'($urandom); pb = 1'($urandom); end
            pin_a = pa; pin_b = pb;
            tick();
            m16_a = pa ? 16'hFFFF : 16'h0000;
            m16_b = pb ? 16'hFFFF : 16'h0000;
            m16_cin = (pa != pb);
            n_cmp++;
            if ({a16, b16, cin16, busy16, done16} !== {m16_a, m16_b, m16_cin, 2'b00}) begin
                n_bad++;
                $display("FAIL bcast_%0d: got a=%h b=%h cin=%b busy=%b done=%b, want a=%h b=%h cin=%b busy=0 done=0",
                         i, a16, b16, cin16, busy16, done16, m16_a, m16_b, m16_cin);
            end
        end
        mode16 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            pin_a = 1'($urandom); pin_b = 1'($urandom); start16 = 1'($urandom);
            tick();
            n_cmp++;
            if ({a16, b16, cin16, busy16, done16} !== {m16_a, m16_b, m16_cin, 2'b00}) begin
                n_bad++;
                $display("FAIL hold_%0d: got a=%h b=%h cin=%b busy=%b done=%b, want a=%h b=%h cin=%b busy=0 done=0",
                         i, a16, b16, cin16, busy16, done16, m16_a, m16_b, m16_cin);
            end
        end
        start16 = 1'b0;
    endtask

    // One SHIFT load on the N=4 instance, starting from IDLE (or from the
    // done cycle of a previous load). va/vb hold the bits in the order they
    // are presented: element i is driven for edge t+1+i. abort_at < 4 aborts
    // with the pins of that step.
    task automatic run_shift4(input logic [3:0] va, input logic [3:0] vb,
                              input bit pa0, input int abort_at, input string tag);
        mode4 = 2'b01;
        pin_a = pa0; pin_b = 1'($urandom);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        m4_cin = pa0;
        n_cmp++;
        if ({cin4, b4, a4, busy4, done4} !== {m4_cin, m4_b, m4_a, 2'b10}) begin
            n_bad++;
            $display("FAIL %s_start: got cin=%b b=%h a=%h busy=%b done=%b, want cin=%b b=%h a=%h busy=1 done=0",
                     tag, cin4, b4, a4, busy4, done4, m4_cin, m4_b, m4_a);
        end
        for (int i = 0; i < 4; i++) begin
            bit eb, ed;
            pin_a = va[i]; pin_b = vb[i];
            abort4 = (i == abort_at);
            tick();
            abort4 = 1'b0;
            if (i == abort_at) begin
                eb = 1'b0; ed = 1'b0;
            end else if (i == 3) begin
                // The first bit sampled lands in bit 0, so the presented
                // sequence read LSB-first is exactly the loaded operand.
                m4_a = va; m4_b = vb;
                eb = 1'b0; ed = 1'b1;
            end else begin
                eb = 1'b1; ed = 1'b0;
            end
            n_cmp++;
            if ({cin4, b4, a4, busy4, done4} !== {m4_cin, m4_b, m4_a, eb, ed}) begin
                n_bad++;
                $display("FAIL %s_bit%0d: got cin=%b b=%h a=%h busy=%b done=%b, want cin=%b b=%h a=%h busy=%b done=%b",
                         tag, i, cin4, b4, a4, busy4, done4, m4_cin, m4_b, m4_a, eb, ed);
            end
            if (i == abort_at) return;
        end
    endtask

    // One idle cycle on the N=4 instance: no done, operands held.
    task automatic idle4(input string tag);
        mode4 = 2'b01;
        pin_a = 1'($urandom); pin_b = 1'($urandom);
        tick();
        n_cmp++;
        if ({cin4, b4, a4, busy4, done4} !== {m4_cin, m4_b, m4_a, 2'b00}) begin
            n_bad++;
            $display("FAIL %s_idle: got cin=%b b=%h a=%h busy=%b done=%b, want cin=%b b=%h a=%h busy=0 done=0",
                     tag, cin4, b4, a4, busy4, done4, m4_cin, m4_b, m4_a);
        end
    endtask

    task automatic test_shift;
        // Bits presented in time order: a = 1,0,1,1 and b = 0,0,1,0.
        run_shift4(4'b1101, 4'b0100, 1'b1, 99, "shift_dir");
        idle4("shift_dir");
        for (int r = 0; r < 6; r++) begin
            run_shift4(4'($urandom), 4'($urandom), 1'($urandom), 99, "shift_rnd");
            idle4("shift_rnd");
        end
    endtask

    task automatic test_back_to_back;
        // The second start is presented in the cycle done is high.
        run_shift4(4'($urandom), 4'($urandom), 1'($urandom), 99, "b2b_first");
        run_shift4(4'($urandom), 4'($urandom), 1'($urandom), 99, "b2b_second");
        idle4("b2b");
    endtask

    task automatic test_shift_abort;
        run_shift4(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "shift_abort");
        idle4("shift_abort");
        idle4("shift_abort_late");
        // Abort together with start in IDLE keeps the block idle.
        mode4 = 2'b01; start4 = 1'b1; abort4 = 1'b1; pin_a = ~m4_cin;
        tick();
        start4 = 1'b0; abort4 = 1'b0;
        n_cmp++;
        if ({cin4, b4, a4, busy4, done4} !== {m4_cin, m4_b, m4_a, 2'b00}) begin
            n_bad++;
            $display("FAIL shift_start_abort: got cin=%b b=%h a=%h busy=%b done=%b, want cin=%b b=%h a=%h busy=0 done=0",
                     cin4, b4, a4, busy4, done4, m4_cin, m4_b, m4_a);
        end
        run_shift4(4'($urandom), 4'($urandom), 1'($urandom), 99, "shift_after_abort");
    endtask

    task automatic test_reset_mid_shift;
        mode4 = 2'b01; pin_a = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        pin_a = 1'($urandom); pin_b = 1'($urandom);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        zero_model();
        n_cmp++;
        if ({cin4, b4, a4, busy4, done4} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_shift: got cin=%b b=%h a=%h busy=%b done=%b, want all zero",
                     cin4, b4, a4, busy4, done4);
        end
        #2 rst = 1'b0;
        run_shift4(4'($urandom), 4'($urandom), 1'($urandom), 99, "shift_after_reset");
        idle4("shift_after_reset");
    endtask

    // Full COUNT sweep on the N=2 instance: value at edge t+k is k mod 32.
    task automatic test_count(input bit wiggle, input string tag);
        mode2 = 2'b10; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        m2_val = '0;
        n_cmp++;
        if ({cin2, b2, a2, busy2, done2} !== {m2_val, 2'b10}) begin
            n_bad++;
            $display("FAIL %s_k0: got value=%0d busy=%b done=%b, want value=0 busy=1 done=0",
                     tag, {cin2, b2, a2}, busy2, done2);
        end
        for (int k = 1; k <= 32; k++) begin
            bit eb, ed;
            if (wiggle) mode2 = 2'($urandom);
            tick();
            m2_val = 5'(k % 32);
            eb = (k < 32);
            ed = (k == 32);
            n_cmp++;
            if ({cin2, b2, a2, busy2, done2} !== {m2_val, eb, ed}) begin
                n_bad++;
                $display("FAIL %s_k%0d: got value=%0d busy=%b done=%b, want value=%0d busy=%b done=%b",
                         tag, k, {cin2, b2, a2}, busy2, done2, m2_val, eb, ed);
            end
            if (k == 31) begin
                n_cmp++;
                if (cin2 !== 1'b1 || b2 !== 2'd3 || a2 !== 2'd3) begin
                    n_bad++;
                    $display("FAIL %s_allones: got cin=%b b=%0d a=%0d, want cin=1 b=3 a=3",
                             tag, cin2, b2, a2);
                end
            end
        end
        mode2 = 2'b10;
        tick();
        n_cmp++;
        if ({cin2, b2, a2, busy2, done2} !== {m2_val, 2'b00}) begin
            n_bad++;
            $display("FAIL %s_after: got value=%0d busy=%b done=%b, want value=%0d busy=0 done=0",
                     tag, {cin2, b2, a2}, busy2, done2, m2_val);
        end
    endtask

    task automatic test_count_abort;
        mode2 = 2'b10; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        m2_val = 5'd5;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({cin2, b2, a2, busy2, done2} !== {m2_val, 2'b00}) begin
                n_bad++;
                $display("FAIL count_abort_%0d: got value=%0d busy=%b done=%b, want value=5 busy=0 done=0",
                         i, {cin2, b2, a2}, busy2, done2);
            end
            tick();
        end
        start2 = 1'b1; abort2 = 1'b1;
        tick();
        start2 = 1'b0; abort2 = 1'b0;
        n_cmp++;
        if ({cin2, b2, a2, busy2, done2} !== {m2_val, 2'b00}) begin
            n_bad++;
            $display("FAIL count_start_abort: got value=%0d busy=%b done=%b, want value=5 busy=0 done=0",
                     {cin2, b2, a2}, busy2, done2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bcast();
        test_shift();
        test_back_to_back();
        test_shift_abort();
        test_reset_mid_shift();
        test_count(1'b0, "count");
        test_count(1'b1, "count_modechg");
        test_count_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
